// File: rtl/icache_refill_mem.sv
// Memory-side responder for the ICache refill handshake: serves one 128-bit
// line from a preloadable word array after a fixed latency.
module icache_refill_mem #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [31:0]  Icache_addr_i,
  input  logic         Icache_valid_req_i,
  output logic         mem_ready_o,
  output logic [127:0] mem_data_o,
  input  logic         load_en_i,
  input  logic [31:0]  load_addr_i,
  input  logic [31:0]  load_data_i,
  output logic         busy_o
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t         state;
  logic [3:0]     cnt;
  logic [AW-1:0]  base_q;
  logic [31:0]    mem [DEPTH_WORDS];

  logic [AW-1:0]  load_idx;
  logic [AW-1:0]  req_base;
  logic           unused_addr_bits;

  // Word index of the first word in the requested line; upper bits wrap away.
  assign req_base = Icache_addr_i[AW+1:2] & ~AW'(3);
  assign load_idx = load_addr_i[AW+1:2];
  assign unused_addr_bits = ^{Icache_addr_i[31:AW+2], Icache_addr_i[1:0],
                              load_addr_i[31:AW+2], load_addr_i[1:0]};

  // NOTE: the backing array has no reset; clearing it would turn the storage
  // into thousands of reset flops and reset must preserve preloaded contents.
  always_ff @(posedge clk) begin
    if (load_en_i) mem[load_idx] <= load_data_i;
  end

  // NOTE: non-blocking assignments everywhere in sequential logic, so the
  // response registered below samples the array as it was before this edge's
  // load -- a same-edge load is not visible in the response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      base_q      <= '0;
      mem_ready_o <= 1'b0;
      mem_data_o  <= 128'h0;
    end else begin
      case (state)
        IDLE: begin
          if (Icache_valid_req_i) begin
            base_q <= req_base;
            cnt    <= 4'(LATENCY - 1);
            state  <= WAIT;
          end
        end
        WAIT: begin
          if (!Icache_valid_req_i) begin
            cnt   <= 4'd0;
            state <= IDLE;
          end else if (cnt == 4'd0) begin
            mem_data_o  <= {mem[base_q | AW'(3)], mem[base_q | AW'(2)],
                            mem[base_q | AW'(1)], mem[base_q]};
            mem_ready_o <= 1'b1;
            state       <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          mem_ready_o <= 1'b0;
          state       <= DONE;
        end
        DONE: begin
          // A requester still holding valid must not get a second line.
          if (!Icache_valid_req_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy_o = (state != IDLE);

endmodule

// File: tb/tb_icache_refill_mem.sv
// Directed testbench for icache_refill_mem with default parameters
// (DEPTH_WORDS=1024, LATENCY=3).
module tb_icache_refill_mem;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  Icache_addr_i;
  logic         Icache_valid_req_i;
  logic         mem_ready_o;
  logic [127:0] mem_data_o;
  logic         load_en_i;
  logic [31:0]  load_addr_i;
  logic [31:0]  load_data_i;
  logic         busy_o;

  int errors = 0;
  int checks = 0;

  localparam logic [127:0] LINE0 = 128'h1111_1111_1111_0000_1011_0000_1111_0000;
  localparam logic [127:0] LINE1 = 128'h7777_0007_6666_0006_5555_0005_4444_0004;

  icache_refill_mem dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .Icache_addr_i      (Icache_addr_i),
    .Icache_valid_req_i (Icache_valid_req_i),
    .mem_ready_o        (mem_ready_o),
    .mem_data_o         (mem_data_o),
    .load_en_i          (load_en_i),
    .load_addr_i        (load_addr_i),
    .load_data_i        (load_data_i),
    .busy_o             (busy_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within 200000 time units");
    $fatal(1, "timeout");
  end

  task automatic load_word(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    load_en_i   = 1'b1;
    load_addr_i = addr;
    load_data_i = data;
    @(negedge clk);
    load_en_i   = 1'b0;
  endtask

  // Raise valid with addr before edge 1, hold it for n_edges edges, optionally
  // pulse load_en_i before edge load_edge, then drop valid for one more edge.
  task automatic run_req(input logic [31:0] addr, input int n_edges, input int load_edge,
                         output int first_pulse, output int pulses, output int busy_low);
    first_pulse = 0;
    pulses      = 0;
    busy_low    = 0;
    for (int e = 1; e <= n_edges; e++) begin
      @(negedge clk);
      if (e == 1) begin
        Icache_addr_i      = addr;
        Icache_valid_req_i = 1'b1;
      end else begin
        Icache_addr_i      = 32'hFFFF_FFF0;
      end
      load_en_i = (e == load_edge);
      @(posedge clk);
      #1;
      if (mem_ready_o) begin
        pulses++;
        if (first_pulse == 0) first_pulse = e;
      end
      if (!busy_o) busy_low++;
    end
    @(negedge clk);
    Icache_valid_req_i = 1'b0;
    load_en_i          = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n              = 1'b0;
    Icache_addr_i      = 32'h0;
    Icache_valid_req_i = 1'b0;
    load_en_i          = 1'b0;
    load_addr_i        = 32'h0;
    load_data_i        = 32'h0;
    #12;
    checks++; if (mem_ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", mem_ready_o); end
    checks++; if (mem_data_o !== 128'h0) begin errors++; $display("FAIL reset_data: got %h want 0", mem_data_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_preload();
    load_word(32'h0000_0000, 32'h1111_0000);
    load_word(32'h0000_0004, 32'h1011_0000);
    load_word(32'h0000_0008, 32'h1111_0000);
    load_word(32'h0000_000C, 32'h1111_1111);
    load_word(32'h0000_0010, 32'h4444_0004);
    load_word(32'h0000_0014, 32'h5555_0005);
    load_word(32'h0000_0018, 32'h6666_0006);
    load_word(32'h0000_001C, 32'h7777_0007);
  endtask

  task automatic test_basic();
    int fp, np, bl;
    run_req(32'h0000_0001, 6, 0, fp, np, bl);
    checks++; if (fp !== 4) begin errors++; $display("FAIL basic_latency: pulse at edge %0d want 4", fp); end
    checks++; if (np !== 1) begin errors++; $display("FAIL basic_pulses: got %0d want 1", np); end
    checks++; if (mem_data_o !== LINE0) begin errors++; $display("FAIL basic_data: got %h want %h", mem_data_o, LINE0); end
  endtask

  task automatic test_hold();
    int fp, np, bl;
    run_req(32'h0000_0001, 14, 0, fp, np, bl);
    checks++; if (np !== 1) begin errors++; $display("FAIL hold_pulses: got %0d want 1", np); end
    checks++; if (bl !== 0) begin errors++; $display("FAIL hold_busy: busy low on %0d edges want 0", bl); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL hold_idle: busy %b want 0 after valid drop", busy_o); end
    run_req(32'h0000_0010, 6, 0, fp, np, bl);
    checks++; if (fp !== 4) begin errors++; $display("FAIL hold_next_accept: pulse at edge %0d want 4", fp); end
    checks++; if (mem_data_o !== LINE1) begin errors++; $display("FAIL hold_next_data: got %h want %h", mem_data_o, LINE1); end
  endtask

  task automatic test_wrap();
    int fp, np, bl;
    run_req(32'h0000_0000, 6, 0, fp, np, bl);
    run_req(32'h0000_4010, 6, 0, fp, np, bl);
    checks++; if (fp !== 4) begin errors++; $display("FAIL wrap_latency: pulse at edge %0d want 4", fp); end
    checks++; if (mem_data_o !== LINE1) begin errors++; $display("FAIL wrap_data: got %h want %h", mem_data_o, LINE1); end
  endtask

  task automatic test_abort();
    int fp, np, bl, late;
    run_req(32'h0000_0000, 2, 0, fp, np, bl);
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy_o); end
    late = 0;
    for (int e = 0; e < 4; e++) begin
      @(posedge clk);
      #1;
      if (mem_ready_o) late++;
    end
    checks++; if ((np + late) !== 0) begin errors++; $display("FAIL abort_pulses: got %0d want 0", np + late); end
    checks++; if (mem_data_o !== LINE1) begin errors++; $display("FAIL abort_data: got %h want %h", mem_data_o, LINE1); end
  endtask

  task automatic test_reset_mid();
    int fp;
    @(negedge clk);
    Icache_addr_i      = 32'h0000_0000;
    Icache_valid_req_i = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (mem_ready_o !== 1'b0) begin errors++; $display("FAIL rstmid_ready: got %b want 0", mem_ready_o); end
    checks++; if (mem_data_o !== 128'h0) begin errors++; $display("FAIL rstmid_data: got %h want 0", mem_data_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy_o); end
    @(negedge clk);
    rst_n = 1'b1;
    fp = 0;
    for (int e = 1; e <= 6; e++) begin
      @(posedge clk);
      #1;
      if (mem_ready_o && fp == 0) fp = e;
    end
    checks++; if (fp !== 4) begin errors++; $display("FAIL rstmid_accept: pulse at edge %0d want 4", fp); end
    checks++; if (mem_data_o !== LINE0) begin errors++; $display("FAIL rstmid_retained: got %h want %h", mem_data_o, LINE0); end
    @(negedge clk);
    Icache_valid_req_i = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_load_collision();
    int fp, np, bl;
    load_addr_i = 32'h0000_0000;
    load_data_i = 32'hDEAD_BEEF;
    run_req(32'h0000_0000, 5, 4, fp, np, bl);
    checks++; if (mem_data_o !== LINE0) begin errors++; $display("FAIL collide_old: got %h want %h", mem_data_o, LINE0); end
    run_req(32'h0000_0000, 6, 0, fp, np, bl);
    checks++; if (mem_data_o[31:0] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL collide_new_w0: got %h want deadbeef", mem_data_o[31:0]); end
    checks++; if (mem_data_o[127:32] !== LINE0[127:32]) begin errors++; $display("FAIL collide_new_rest: got %h want %h", mem_data_o[127:32], LINE0[127:32]); end
  endtask

  initial begin
    test_reset();
    test_preload();
    test_basic();
    test_hold();
    test_wrap();
    test_abort();
    test_reset_mid();
    test_load_collision();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/icache_refill_mem.md
ICACHE_REFILL_MEM -- requirements
Module: icache_refill_mem

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, number of 32-bit words in the backing array (power of two, >=4).
REQ-002 Parameter LATENCY, default 3, cycles from request acceptance to response (legal range 1..15).
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port Icache_addr_i  input  32  refill byte address from ICache; bits [3:0] ignored.
REQ-006 Port Icache_valid_req_i  input  1  refill request valid, held high by requester until response.
REQ-007 Port mem_ready_o  output  1  one-cycle pulse: mem_data_o holds the requested line.
REQ-008 Port mem_data_o  output  128  refill line; word 0 of line in [31:0], word 3 in [127:96].
REQ-009 Port load_en_i  input  1  preload write strobe for the backing array.
REQ-010 Port load_addr_i  input  32  preload byte address; bits [1:0] ignored.
REQ-011 Port load_data_i  input  32  preload word.
REQ-012 Port busy_o  output  1  high whenever the state is not IDLE.

Function
REQ-013 Block SHALL be the memory-side responder of the ICache refill handshake: one 128-bit line per accepted request.
REQ-014 State machine SHALL have states IDLE, WAIT, RESP, DONE.
REQ-015 IDLE: on an edge with Icache_valid_req_i=1, latch line index = Icache_addr_i[31:4] modulo DEPTH_WORDS/4, load counter with LATENCY-1, go to WAIT.
REQ-016 WAIT: counter decrements each edge; on the edge where counter=0 and valid still high, register the four words of the latched line into mem_data_o, assert mem_ready_o, go to RESP.
REQ-017 Resulting latency: mem_ready_o SHALL rise exactly LATENCY edges after the acceptance edge.
REQ-018 RESP: mem_ready_o high for exactly one cycle; next edge deassert it and go to DONE.
REQ-019 DONE: stay until an edge sees Icache_valid_req_i=0, then go to IDLE; a held-high valid SHALL never trigger a second response.
REQ-020 Abort: if Icache_valid_req_i=0 on any edge while in WAIT, return to IDLE, no mem_ready_o pulse, mem_data_o unchanged.
REQ-021 Icache_addr_i changes after acceptance SHALL be ignored; the latched index is served.
REQ-022 mem_data_o SHALL hold the last returned line until the next response.
REQ-023 Load: on an edge with load_en_i=1, array word at index load_addr_i[31:2] modulo DEPTH_WORDS takes load_data_i; legal in every state.
REQ-024 Load vs. read same edge: a load on the edge that enters RESP SHALL NOT be visible in that response (old data returned); loads on earlier edges SHALL be visible.
REQ-025 Addresses beyond the array SHALL wrap modulo array size; no error indication.
REQ-026 Backing array content SHALL be undefined after power-up and is not cleared by reset.

Reset
REQ-027 rst_n=0 SHALL asynchronously force state IDLE, counter 0, mem_ready_o=0, mem_data_o=128'h0, busy_o=0.
REQ-028 Reset asserted mid-transaction SHALL abandon it with no mem_ready_o pulse; array contents retained.
REQ-029 After rst_n rises, a request held high SHALL be accepted on the first edge with rst_n=1.

Verification
REQ-030 Preload words 0..3 = 32'h1111_0000, 32'h1011_0000, 32'h1111_0000, 32'h1111_1111; request addr 32'h0000_0001, hold valid -> mem_ready_o pulses once, 3 edges after acceptance, mem_data_o = 128'h1111_1111_1111_0000_1011_0000_1111_0000.
REQ-031 Same request, valid held 10 cycles after the pulse -> exactly one pulse, busy_o stays high until valid drops, then next request is accepted one edge after IDLE re-entry.
REQ-032 Request addr 32'h0000_4010 with DEPTH_WORDS=1024 -> line index 1 (wrap) returned, words 4..7.
REQ-033 Drop valid after 1 WAIT cycle -> no pulse, busy_o low next cycle, mem_data_o unchanged.
REQ-034 Assert rst_n=0 in WAIT -> mem_ready_o, mem_data_o, busy_o zero immediately (without clock edge); re-request returns preloaded data.
REQ-035 Load word 0 with 32'hDEAD_BEEF on the edge entering RESP -> response carries old word 0; next request returns 32'hDEAD_BEEF in [31:0].
